// File: rtl/ysyx_22040759_fetch_ctrl.sv
// Fetch/commit sequencer: REQ -> WAIT -> EXEC per instruction, parks in HALT on ebreak or bus fault.
// Define FETCH_TIMEOUT_EN to add a REQ+WAIT watchdog that halts with code 3 after TIMEOUT_CYCLES.
module ysyx_22040759_fetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        stall,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        commit,
    output logic        halt,
    output logic [1:0]  halt_code,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);
    localparam logic [2:0]  ST_RST  = 3'd0;
    localparam logic [2:0]  ST_REQ  = 3'd1;
    localparam logic [2:0]  ST_WAIT = 3'd2;
    localparam logic [2:0]  ST_EXEC = 3'd3;
    localparam logic [2:0]  ST_HALT = 3'd4;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [1:0]  HC_NONE = 2'd0;
    localparam logic [1:0]  HC_EBRK = 2'd1;
    localparam logic [1:0]  HC_BUS  = 2'd2;
    localparam logic [1:0]  HC_TMO  = 2'd3;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [1:0]  r_halt_code;
    logic [1:0]  w_next_code;
    logic [31:0] r_inst;
    logic [31:0] r_addr;
    logic        r_req_first;
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;
    logic        w_in_req;
    logic        w_in_wait;
    logic        w_in_exec;
    logic        w_tmo_hit;
    logic        w_commit;
    logic        w_addr_live;

    assign w_in_req  = (r_state == ST_REQ);
    assign w_in_wait = (r_state == ST_WAIT);
    assign w_in_exec = (r_state == ST_EXEC);
    assign w_commit  = w_in_exec && !stall && (r_inst != EBREAK);
    // First REQ cycle forwards the live PC so a commit-driven PC update is already visible.
    assign w_addr_live = w_in_req && r_req_first;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 32'd1) > 8) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 8;
    logic [TMO_W-1:0] r_tmo;

    // Counts cycles spent in REQ+WAIT of the current fetch, cleared elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo <= {TMO_W{1'b0}};
        end else if (w_in_req || w_in_wait) begin
            r_tmo <= r_tmo + TMO_W'(1'b1);
        end else begin
            r_tmo <= {TMO_W{1'b0}};
        end
    end

    assign w_tmo_hit = (w_in_req || w_in_wait) && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 32'd1));
`else
    assign w_tmo_hit = 1'b0 && (TIMEOUT_CYCLES != 32'd0);
`endif

    // Next-state and halt-cause selection; a WAIT response beats a coincident timeout.
    always_comb begin
        w_next_state = r_state;
        w_next_code  = r_halt_code;
        case (r_state)
            ST_RST: begin
                w_next_state = ST_REQ;
            end
            ST_REQ: begin
                if (w_tmo_hit) begin
                    w_next_state = ST_HALT;
                    w_next_code  = HC_TMO;
                end else if (imem_req_ready) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid && imem_rsp_err) begin
                    w_next_state = ST_HALT;
                    w_next_code  = HC_BUS;
                end else if (imem_rsp_valid) begin
                    w_next_state = ST_EXEC;
                end else if (w_tmo_hit) begin
                    w_next_state = ST_HALT;
                    w_next_code  = HC_TMO;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_EXEC: begin
                if (stall) begin
                    w_next_state = ST_EXEC;
                end else if (r_inst == EBREAK) begin
                    w_next_state = ST_HALT;
                    w_next_code  = HC_EBRK;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_RST;
                w_next_code  = HC_NONE;
            end
        endcase
    end

    // State, halt cause, instruction latch and fetch address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RST;
            r_halt_code <= HC_NONE;
            r_inst      <= 32'h0000_0000;
            r_addr      <= 32'h0000_0000;
            r_req_first <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_halt_code <= w_next_code;
            r_req_first <= (w_next_state == ST_REQ) && (r_state != ST_REQ);
            if (w_in_wait && imem_rsp_valid && !imem_rsp_err) begin
                r_inst <= imem_rsp_data;
            end else begin
                r_inst <= r_inst;
            end
            if (w_addr_live) begin
                r_addr <= pc;
            end else begin
                r_addr <= r_addr;
            end
        end
    end

    // Performance counters; both wrap silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt   <= 64'd0;
            r_instret_cnt <= 64'd0;
        end else begin
            if ((r_state != ST_RST) && (r_state != ST_HALT)) begin
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
            end else begin
                r_cycle_cnt <= r_cycle_cnt;
            end
            if (w_commit) begin
                r_instret_cnt <= r_instret_cnt + 64'd1;
            end else begin
                r_instret_cnt <= r_instret_cnt;
            end
        end
    end

    assign imem_req_valid = w_in_req;
    assign imem_req_addr  = w_addr_live ? pc : r_addr;
    assign inst           = r_inst;
    assign inst_valid     = w_in_exec;
    assign commit         = w_commit;
    assign halt           = (r_state == ST_HALT);
    assign halt_code      = r_halt_code;
    assign cycle_cnt      = r_cycle_cnt;
    assign instret_cnt    = r_instret_cnt;
endmodule

// File: tb/tb_ysyx_22040759_fetch_ctrl.sv
// Randomized self-checking bench for ysyx_22040759_fetch_ctrl; expectations come from a per-instruction
// phase model (REQ cycles, WAIT cycles, EXEC cycles) plus a PC / counter scoreboard.
module tb_ysyx_22040759_fetch_ctrl;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] PC0    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = PC0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        imem_rsp_err = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        commit;
    logic        halt;
    logic [1:0]  halt_code;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    logic [31:0] pc_m = PC0;
    logic [63:0] cyc_m = 64'd0;
    logic [63:0] ret_m = 64'd0;
    logic        pend_commit = 1'b0;

    always #5 clk = ~clk;

    ysyx_22040759_fetch_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .stall(stall), .inst(inst), .inst_valid(inst_valid), .commit(commit),
        .halt(halt), .halt_code(halt_code), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    // One clock cycle: external PC register reacts to last commit, inputs change mid-cycle, sample 1ns later.
    task automatic drive(input logic rdy, input logic rv, input logic [31:0] data, input logic err, input logic stl);
        @(negedge clk);
        if (pend_commit) begin
            pc = pc + 32'd4;
            pend_commit = 1'b0;
        end
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        stall          = stl;
        #1;
        pend_commit = commit;
        if (imem_req_valid && imem_req_ready) hs_cnt++;
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; stall = 1'b0;
        pc = PC0; pc_m = PC0; cyc_m = 64'd0; ret_m = 64'd0; pend_commit = 1'b0;
    endtask

    // Release at a falling edge; the remaining half cycle is the RST cycle, optionally with a stray response.
    task automatic release_reset(input logic late);
        @(negedge clk);
        rst = 1'b1;
        imem_rsp_valid = late;
        imem_rsp_data  = $urandom;
        #1;
    endtask

    // One instruction: d_r not-ready REQ cycles, d_s empty WAIT cycles, k stalled EXEC cycles.
    task automatic run_instr(input int d_r, input int d_s, input int k, input logic [31:0] instr, input logic junk);
        for (int c = 0; c <= d_r; c++) begin
            drive(c == d_r, junk, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== pc_m) begin
                failures++;
                $display("FAIL req_phase: valid=%b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_req_addr, pc_m);
            end
            checks++;
            if (inst_valid !== 1'b0 || commit !== 1'b0 || halt !== 1'b0) begin
                failures++;
                $display("FAIL req_idle: inst_valid=%b commit=%b halt=%b expected 0 0 0", inst_valid, commit, halt);
            end
            checks++;
            if (cycle_cnt !== cyc_m || instret_cnt !== ret_m) begin
                failures++;
                $display("FAIL req_cnt: cycle=%0d instret=%0d expected %0d %0d", cycle_cnt, instret_cnt, cyc_m, ret_m);
            end
            cyc_m++;
        end
        for (int c = 0; c <= d_s; c++) begin
            if (c == d_s) drive(1'($urandom_range(0, 1)), 1'b1, instr, 1'b0, 1'($urandom_range(0, 1)));
            else          drive(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || commit !== 1'b0 || halt !== 1'b0) begin
                failures++;
                $display("FAIL wait_phase: req_valid=%b inst_valid=%b commit=%b halt=%b expected 0 0 0 0",
                         imem_req_valid, inst_valid, commit, halt);
            end
            checks++;
            if (cycle_cnt !== cyc_m) begin
                failures++;
                $display("FAIL wait_cnt: cycle=%0d expected %0d", cycle_cnt, cyc_m);
            end
            cyc_m++;
        end
        for (int c = 0; c <= k; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), c < k);
            checks++;
            if (inst_valid !== 1'b1 || inst !== instr || imem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL exec_inst: inst_valid=%b inst=%h req_valid=%b expected 1 %h 0", inst_valid, inst, imem_req_valid, instr);
            end
            checks++;
            if (commit !== ((c == k) && (instr != EBREAK))) begin
                failures++;
                $display("FAIL exec_commit: commit=%b expected %b (cycle %0d of %0d)", commit, (c == k) && (instr != EBREAK), c, k);
            end
            checks++;
            if (cycle_cnt !== cyc_m || instret_cnt !== ret_m) begin
                failures++;
                $display("FAIL exec_cnt: cycle=%0d instret=%0d expected %0d %0d", cycle_cnt, instret_cnt, cyc_m, ret_m);
            end
            cyc_m++;
        end
        if (instr != EBREAK) begin
            ret_m++;
            pc_m = pc_m + 32'd4;
        end
    endtask

    task automatic test_reset();
        assert_reset();
        @(negedge clk);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || inst !== 32'h0 || inst_valid !== 1'b0 ||
            commit !== 1'b0 || halt !== 1'b0 || halt_code !== 2'd0 || cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
            failures++;
            $display("FAIL reset_values: valid=%b addr=%h inst=%h iv=%b commit=%b halt=%b code=%0d cyc=%0d ret=%0d expected all zero",
                     imem_req_valid, imem_req_addr, inst, inst_valid, commit, halt, halt_code, cycle_cnt, instret_cnt);
        end
        release_reset(1'b0);
    endtask

    task automatic test_basic();
        run_instr(0, 0, 0, ADDI, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (instret_cnt !== 64'd1 || imem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_after: instret=%0d req_valid=%b expected 1 1", instret_cnt, imem_req_valid);
        end
    endtask

    task automatic test_ready_hold();
        int hs0;
        hs0 = hs_cnt;
        run_instr(4, 0, 0, ADDI, 1'b1);
        checks++;
        if (hs_cnt - hs0 !== 1) begin
            failures++;
            $display("FAIL ready_hold_handshakes: got %0d expected 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_stall();
        run_instr(0, 1, 3, 32'h0020_8113, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] instr;
        for (int n = 0; n < 30; n++) begin
            instr = $urandom;
            if (instr == EBREAK) instr = instr ^ 32'h1;
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), instr, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_ebreak();
        run_instr(1, 0, 1, EBREAK, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
            checks++;
            if (halt !== 1'b1 || halt_code !== 2'd1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || commit !== 1'b0) begin
                failures++;
                $display("FAIL ebreak_halt: halt=%b code=%0d req_valid=%b iv=%b commit=%b expected 1 1 0 0 0",
                         halt, halt_code, imem_req_valid, inst_valid, commit);
            end
            checks++;
            if (cycle_cnt !== cyc_m || instret_cnt !== ret_m || pc !== pc_m) begin
                failures++;
                $display("FAIL ebreak_frozen: cycle=%0d instret=%0d pc=%h expected %0d %0d %h", cycle_cnt, instret_cnt, pc, cyc_m, ret_m, pc_m);
            end
        end
    endtask

    task automatic test_bus_err();
        logic [31:0] prev;
        prev = $urandom;
        if (prev == EBREAK) prev = ADDI;
        @(negedge clk);
        assert_reset();
        release_reset(1'b0);
        run_instr(0, 0, 0, prev, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, $urandom, 1'b1, 1'b0);
        checks++;
        if (inst_valid !== 1'b0 || halt !== 1'b0) begin
            failures++;
            $display("FAIL bus_err_wait: inst_valid=%b halt=%b expected 0 0", inst_valid, halt);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (halt !== 1'b1 || halt_code !== 2'd2 || inst !== prev || commit !== 1'b0) begin
            failures++;
            $display("FAIL bus_err_halt: halt=%b code=%0d inst=%h commit=%b expected 1 2 %h 0", halt, halt_code, inst, commit, prev);
        end
    endtask

    task automatic test_reset_wait();
        @(negedge clk);
        assert_reset();
        release_reset(1'b0);
        run_instr(0, 0, 0, ADDI, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        assert_reset();
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || inst !== 32'h0 || inst_valid !== 1'b0 ||
            commit !== 1'b0 || halt !== 1'b0 || halt_code !== 2'd0 || cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_wait: valid=%b addr=%h inst=%h iv=%b cyc=%0d ret=%0d expected all zero",
                     imem_req_valid, imem_req_addr, inst, inst_valid, cycle_cnt, instret_cnt);
        end
        release_reset(1'b1);
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL late_rsp_rst: iv=%b inst=%h req_valid=%b expected 0 0 0", inst_valid, inst, imem_req_valid);
        end
        run_instr(0, 0, 0, ADDI, 1'b1);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        assert_reset();
        release_reset(1'b0);
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            checks++;
            if (imem_req_valid !== 1'b1 || halt !== 1'b0) begin
                failures++;
                $display("FAIL timeout_req: cycle %0d req_valid=%b halt=%b expected 1 0", c, imem_req_valid, halt);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
`ifdef FETCH_TIMEOUT_EN
        if (halt !== 1'b1 || halt_code !== 2'd3 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_halt: halt=%b code=%0d req_valid=%b expected 1 3 0", halt, halt_code, imem_req_valid);
        end
`else
        if (halt !== 1'b0 || halt_code !== 2'd0 || imem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL no_timeout: halt=%b code=%0d req_valid=%b expected 0 0 1", halt, halt_code, imem_req_valid);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_hold();
        test_stall();
        test_random();
        test_ebreak();
        test_bus_err();
        test_reset_wait();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
